// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-file
// geometry, controller state encoding and the load-use compare.
package pipe_hazard_ctrl_pkg;

    localparam int ASIZE  = 5;   // register address width
    localparam int DSIZE  = 32;  // datapath width
    localparam int FCNT_W = 2;   // flush counter width, covers FLUSH_CYCLES up to 3

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_MEMWAIT = 2'd3
    } state_t;

    // Load in ID/EXE whose destination feeds a source actually read in ID.
    // r0 is hardwired zero and never creates a dependency.
    function automatic logic load_use_hit(
        input logic             mem_read,
        input logic             write_en,
        input logic [ASIZE-1:0] waddr,
        input logic [ASIZE-1:0] rs1,
        input logic             rs1_used,
        input logic [ASIZE-1:0] rs2,
        input logic             rs2_used
    );
        return mem_read && write_en && (waddr != '0) &&
               (((waddr == rs1) && rs1_used) || ((waddr == rs2) && rs2_used));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: load-use stalls,
// taken-branch flushes, data-memory wait holds, plus perf counters.
// All control outputs are combinational from registered state and inputs.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASIZE-1:0] id_rs1,
    input  logic [ASIZE-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_mem_read,
    input  logic             ex_write_en,
    input  logic [ASIZE-1:0] ex_waddr,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             pc_sel_br,
    output logic             ifid_flush,
    output logic             idexe_bubble,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t              state, state_nxt;
    state_t              resume, resume_nxt;
    state_t              eff;
    logic [FCNT_W-1:0]   fcnt, fcnt_nxt;
    logic                load_use, mem_wait;
    logic                stall_inc, flush_inc;

    assign load_use = load_use_hit(ex_mem_read, ex_write_en, ex_waddr,
                                   id_rs1, id_rs1_used, id_rs2, id_rs2_used);
    assign mem_wait = mem_req && !mem_ready;

    // Next-state and control decode; memory wait beats branch beats load-use.
    always_comb begin
        state_nxt    = state;
        resume_nxt   = resume;
        fcnt_nxt     = fcnt;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        pc_sel_br    = 1'b0;
        ifid_flush   = 1'b0;
        idexe_bubble = 1'b0;
        pipe_hold    = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        // Leaving MEMWAIT behaves as the interrupted state in the same cycle,
        // so a branch frozen in EXE is serviced on the first non-hold cycle.
        eff = (state == ST_MEMWAIT) ? resume : state;

        if (mem_wait) begin
            pipe_hold = 1'b1;
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            stall_inc = 1'b1;
            state_nxt = ST_MEMWAIT;
            if (state != ST_MEMWAIT)
                resume_nxt = (state == ST_FLUSH) ? ST_FLUSH : ST_RUN;
        end else begin
            case (eff)
                ST_FLUSH: begin
                    // EXE holds a bubble here, so ex_branch_taken is ignored.
                    ifid_flush   = 1'b1;
                    idexe_bubble = 1'b1;
                    fcnt_nxt     = fcnt - FCNT_W'(1);
                    state_nxt    = (fcnt <= FCNT_W'(1)) ? ST_RUN : ST_FLUSH;
                end
                default: begin
                    if (ex_branch_taken) begin
                        // Any coincident load-use victim is flushed anyway.
                        pc_sel_br    = 1'b1;
                        ifid_flush   = 1'b1;
                        idexe_bubble = 1'b1;
                        flush_inc    = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_nxt = ST_FLUSH;
                            fcnt_nxt  = FCNT_W'(FLUSH_CYCLES - 1);
                        end else begin
                            state_nxt = ST_RUN;
                        end
                    end else if ((eff == ST_RUN) && load_use) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idexe_bubble = 1'b1;
                        stall_inc    = 1'b1;
                        state_nxt    = ST_LDSTALL;
                    end else begin
                        // LDSTALL lands here: one bubble only, then RUN.
                        state_nxt = ST_RUN;
                    end
                end
            endcase
        end

        // While reset is held the pipe is kept flushed and frozen.
        if (!rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            pc_sel_br    = 1'b0;
            ifid_flush   = 1'b1;
            idexe_bubble = 1'b1;
            pipe_hold    = 1'b0;
            stall_inc    = 1'b0;
            flush_inc    = 1'b0;
        end
    end

    // Controller state, flush countdown and the state to resume after a wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_RUN;
            resume <= ST_RUN;
            fcnt   <= '0;
        end else begin
            state  <= state_nxt;
            resume <= resume_nxt;
            fcnt   <= fcnt_nxt;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, CNT_W=4).
// Stimulus pushes expected outputs per cycle; a monitor pops and compares.
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic       we;
        logic [4:0] wa;
        logic       br;
        logic       mreq;
        logic       mrdy;
    } in_t;

    typedef struct packed {
        logic [5:0]    ctl;   // pc_en, ifid_en, pc_sel_br, ifid_flush, idexe_bubble, pipe_hold
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    localparam logic [5:0] C_RUN  = 6'b110000;
    localparam logic [5:0] C_LU   = 6'b000010;
    localparam logic [5:0] C_BR   = 6'b111110;
    localparam logic [5:0] C_FL   = 6'b110110;
    localparam logic [5:0] C_HOLD = 6'b000001;
    localparam logic [5:0] C_RST  = 6'b000110;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_waddr = '0;
    logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic          ex_mem_read = 1'b0, ex_write_en = 1'b0, ex_branch_taken = 1'b0;
    logic          mem_req = 1'b0, mem_ready = 1'b0;
    logic          pc_en, ifid_en, pc_sel_br, ifid_flush, idexe_bubble, pipe_hold;
    logic [CW-1:0] stall_cnt, flush_cnt;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_mem_read(ex_mem_read), .ex_write_en(ex_write_en), .ex_waddr(ex_waddr),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .pc_sel_br(pc_sel_br),
        .ifid_flush(ifid_flush), .idexe_bubble(idexe_bubble), .pipe_hold(pipe_hold),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic in_t mk(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic mr, input logic we,
                               input logic [4:0] wa, input logic br, input logic mreq,
                               input logic mrdy);
        in_t v;
        v = '{rst:r, rs1:rs1, rs2:rs2, u1:u1, u2:u2, mr:mr, we:we, wa:wa,
              br:br, mreq:mreq, mrdy:mrdy};
        return v;
    endfunction

    // Apply one cycle of inputs just after the edge and queue what it must produce.
    task automatic step(input string nm, input in_t v, input logic [5:0] ctl,
                        input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_rs1_used = v.u1; id_rs2_used = v.u2;
        ex_mem_read = v.mr; ex_write_en = v.we; ex_waddr = v.wa;
        ex_branch_taken = v.br; mem_req = v.mreq; mem_ready = v.mrdy;
        e.ctl = ctl; e.sc = CW'(sc); e.fc = CW'(fc);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are valid every cycle, compare mid-cycle.
    initial begin
        exp_t  e;
        string nm;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = {pc_en, ifid_en, pc_sel_br, ifid_flush, idexe_bubble, pipe_hold};
                n_vec++;
                if (act !== e.ctl || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                    n_bad++;
                    $display("FAIL %s: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                             nm, act, stall_cnt, flush_cnt, e.ctl, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        in_t idle, lu3;
        int  s;
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu3  = mk(1, 3, 0, 1, 0, 1, 1, 3, 0, 0, 0);

        step("reset",        mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_RST, 0, 0);
        step("run_idle",     idle, C_RUN, 0, 0);
        step("lu_rs1_r3",    lu3, C_LU, 0, 0);
        step("ldstall",      lu3, C_RUN, 1, 0);
        step("after_stall",  idle, C_RUN, 1, 0);
        step("waddr0",       mk(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0), C_RUN, 1, 0);
        step("rs2_unused",   mk(1, 0, 5, 0, 0, 1, 1, 5, 0, 0, 0), C_RUN, 1, 0);
        step("lu_rs2",       mk(1, 0, 5, 0, 1, 1, 1, 5, 0, 0, 0), C_LU, 1, 0);
        step("ldstall2",     idle, C_RUN, 2, 0);
        step("branch",       mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_BR, 2, 0);
        step("flush_br_ign", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_FL, 2, 1);
        step("after_flush",  idle, C_RUN, 2, 1);
        step("br_plus_lu",   mk(1, 3, 0, 1, 0, 1, 1, 3, 1, 0, 0), C_BR, 2, 1);
        step("memwait1",     mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_HOLD, 2, 2);
        step("memwait2",     mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_HOLD, 3, 2);
        step("memwait3",     mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_HOLD, 4, 2);
        step("resume_flush", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), C_FL, 5, 2);
        step("back_to_run",  idle, C_RUN, 5, 2);
        step("br_in_wait",   mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), C_HOLD, 5, 2);
        step("br_serviced",  mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), C_BR, 6, 2);
        step("flush_tail",   idle, C_FL, 6, 3);
        step("memwait_pre",  mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_HOLD, 6, 3);
        step("rst_in_wait",  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_RST, 0, 0);
        step("post_reset",   idle, C_RUN, 0, 0);

        // 20 load-use stalls; stall_cnt must stick at 15.
        for (int i = 0; i < 20; i++) begin
            s = (i > 15) ? 15 : i;
            step($sformatf("sat_lu%0d", i), lu3, C_LU, s, 0);
            s = (i + 1 > 15) ? 15 : i + 1;
            step($sformatf("sat_ld%0d", i), idle, C_RUN, s, 0);
        end
        step("sat_final", idle, C_RUN, 15, 0);

        // Let the monitor drain; a stuck queue counts against the run.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
